tally_display: RTL and testbench

//  Consumes the quotient/remainder pair from the repeated-subtraction divider and drives a
//  3-digit multiplexed 7-segment display: quotient tens, quotient ones, remainder.
//  The divider output sweeps for several cycles after every input change, so this block

---
 rtl/tally_display.sv | 164 ++++++++++++++++
 tb/tb_tally_display.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tally_display.sv
// rtl/tally_display.sv - latches settled divider quo/rem and scans them onto a 3-digit 7-segment display
//
// Ports:
//   clk        clock
//   realreset  asynchronous active-high reset
//   quo[3:0]   divider quotient; sweeps while the divider is still working
//   rem[6:0]   divider remainder; only settled once rem < DENOM
//   seg[6:0]   segments {g,f,e,d,c,b,a}, active-low
//   an[2:0]    digit enables, active-low: [2] quotient tens, [1] quotient ones, [0] remainder
//   valid      a settled value has been latched since reset
//   upd        one-cycle pulse when the latched value changes
module tally_display #(
  parameter int DENOM   = 5,
  parameter int SETTLE  = 4,
  parameter int REFRESH = 1000
) (
  input  logic       clk,
  input  logic       realreset,
  input  logic [3:0] quo,
  input  logic [6:0] rem,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       valid,
  output logic       upd
);

  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int RW = (REFRESH < 2) ? 1 : $clog2(REFRESH);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [3:0]    prev_q_q, prev_q_d;
  logic [6:0]    prev_r_q, prev_r_d;
  logic [3:0]    lat_q_q, lat_q_d;
  logic [6:0]    lat_r_q, lat_r_d;
  logic          valid_q, valid_d;
  logic          upd_q, upd_d;
  logic [1:0]    digit_q, digit_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic          changed;
  logic          settled;
  logic          tens;
  logic [3:0]    ones;

  function automatic logic [6:0] enc7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    changed = (quo != prev_q_q) || (rem != prev_r_q);
    // stab_cnt saturates at SETTLE, so equality with SETTLE-1 is true for
    // exactly one edge per stable period: the latch cannot re-fire.
    settled = (stab_cnt_q == SW'(SETTLE - 1)) && !changed && (rem < 7'(DENOM));

    prev_q_d = quo;
    prev_r_d = rem;
    if (changed) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q < SW'(SETTLE)) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end else begin
      stab_cnt_d = stab_cnt_q;
    end

    lat_q_d = lat_q_q;
    lat_r_d = lat_r_q;
    valid_d = valid_q;
    upd_d   = 1'b0;
    if (settled) begin
      lat_q_d = quo;
      lat_r_d = rem;
      valid_d = 1'b1;
      upd_d   = !valid_q || (quo != lat_q_q) || (rem != lat_r_q);
    end

    // Scan timing is independent of the settle/latch path.
    if (ref_cnt_q == RW'(REFRESH - 1)) begin
      ref_cnt_d = '0;
      digit_d   = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
    end else begin
      ref_cnt_d = ref_cnt_q + 1'b1;
      digit_d   = digit_q;
    end

    // quo is only 4 bits, so the tens digit is at most 1.
    tens = (lat_q_q >= 4'd10);
    ones = tens ? (lat_q_q - 4'd10) : lat_q_q;

    seg_d = SEG_BLANK;
    an_d  = 3'b111;
    if (valid_q) begin
      case (digit_q)
        2'd0: begin
          an_d  = 3'b110;
          seg_d = enc7(lat_r_q[3:0]);
        end
        2'd1: begin
          an_d  = 3'b101;
          seg_d = enc7(ones);
        end
        2'd2: begin
          an_d  = 3'b011;
          seg_d = tens ? enc7(4'd1) : SEG_BLANK;
        end
        default: begin
          an_d  = 3'b111;
          seg_d = SEG_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge realreset) begin
    if (realreset) begin
      stab_cnt_q <= '0;
      prev_q_q   <= '0;
      prev_r_q   <= '0;
      lat_q_q    <= '0;
      lat_r_q    <= '0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
      digit_q    <= 2'd0;
      ref_cnt_q  <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= 3'b111;
    end else begin
      stab_cnt_q <= stab_cnt_d;
      prev_q_q   <= prev_q_d;
      prev_r_q   <= prev_r_d;
      lat_q_q    <= lat_q_d;
      lat_r_q    <= lat_r_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      digit_q    <= digit_d;
      ref_cnt_q  <= ref_cnt_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign valid = valid_q;
  assign upd   = upd_q;

endmodule

// File: tb/tb_tally_display.sv
// tb/tb_tally_display.sv - self-checking bench for tally_display against a run-length behavioural model
module tb_tally_display;

  localparam int DENOM   = 5;
  localparam int SETTLE  = 4;
  localparam int REFRESH = 7;

  logic       clk = 1'b0;
  logic       realreset = 1'b1;
  logic [3:0] quo = 4'd0;
  logic [6:0] rem = 7'd0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       valid;
  logic       upd;

  int checks = 0;
  int errors = 0;

  tally_display #(.DENOM(DENOM), .SETTLE(SETTLE), .REFRESH(REFRESH)) dut (
    .clk(clk), .realreset(realreset), .quo(quo), .rem(rem),
    .seg(seg), .an(an), .valid(valid), .upd(upd)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int v);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (v >= 0 && v <= 9) ? tbl[v] : 7'h7F;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a value is latched on the edge where it has been sampled
  // SETTLE+1 times in a row (reset counts as one sample of 0/0).
  int         m_run = 1;
  int         m_last_q = 0, m_last_r = 0;
  bit         m_valid = 0;
  int         m_lq = 0, m_lr = 0;
  int         m_n = 0;
  int         m_d;
  bit         m_fire;
  logic [6:0] e_seg = 7'h7F;
  logic [2:0] e_an = 3'b111;
  bit         e_valid = 0, e_upd = 0;

  always @(posedge clk or posedge realreset) begin
    if (realreset) begin
      m_run = 1; m_last_q = 0; m_last_r = 0;
      m_valid = 0; m_lq = 0; m_lr = 0; m_n = 0;
      e_seg = 7'h7F; e_an = 3'b111; e_valid = 0; e_upd = 0;
    end else begin
      m_d = (m_n / REFRESH) % 3;
      if (!m_valid) begin
        e_seg = 7'h7F; e_an = 3'b111;
      end else if (m_d == 0) begin
        e_an = 3'b110; e_seg = enc(m_lr);
      end else if (m_d == 1) begin
        e_an = 3'b101; e_seg = enc(m_lq % 10);
      end else begin
        e_an = 3'b011; e_seg = (m_lq >= 10) ? enc(1) : 7'h7F;
      end
      if (int'(quo) == m_last_q && int'(rem) == m_last_r) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1; m_last_q = quo; m_last_r = rem;
      end
      m_fire = (m_run == SETTLE + 1) && (rem < DENOM);
      e_upd = m_fire && (!m_valid || int'(quo) != m_lq || int'(rem) != m_lr);
      if (m_fire) begin
        m_lq = quo; m_lr = rem; m_valid = 1;
      end
      e_valid = m_valid;
      m_n++;
    end
  end

  always @(negedge clk) begin
    chk("cyc_seg", seg, e_seg);
    chk("cyc_an", an, e_an);
    chk("cyc_valid", valid, e_valid);
    chk("cyc_upd", upd, e_upd);
  end

  task automatic hold(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      cnt += upd;
    end
  endtask

  task automatic drive(input int q, input int r);
    quo = 4'(q);
    rem = 7'(r);
  endtask

  task automatic wait_an_seg(input string name, input logic [2:0] want, input logic [6:0] want_seg);
    int i;
    for (i = 0; i < 4 * REFRESH; i++) begin
      @(negedge clk);
      if (an == want) break;
    end
    if (an != want) begin
      chk({name, "_timeout"}, an, want);
    end else begin
      chk(name, seg, want_seg);
      chk({name, "_model"}, e_seg, want_seg);
    end
  endtask

  initial begin
    int cnt, tot;
    drive(0, 0);
    realreset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 3'b111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_valid", valid, 0);
    realreset = 1'b0;

    // 1: 0/0 held from reset latches on the 4th edge
    repeat (SETTLE) @(negedge clk);
    chk("t1_valid", valid, 1);
    chk("t1_upd", upd, 1);
    @(negedge clk);
    chk("t1_upd_once", upd, 0);
    wait_an_seg("t1_rem0", 3'b110, 7'h40);
    wait_an_seg("t1_tens_blank", 3'b011, 7'h7F);

    // 2: sweep then hold 2/3
    drive(0, 13); @(negedge clk);
    drive(1, 8);  @(negedge clk);
    drive(2, 3);
    hold(15, cnt);
    chk("t2_single_upd", cnt, 1);
    wait_an_seg("t2_ones", 3'b101, 7'h24);
    wait_an_seg("t2_rem", 3'b110, 7'h30);

    // 3: 12/4 shows 1,2,4
    drive(12, 4);
    hold(8, cnt);
    chk("t3_upd", cnt, 1);
    wait_an_seg("t3_rem", 3'b110, 7'h19);
    wait_an_seg("t3_ones", 3'b101, 7'h24);
    wait_an_seg("t3_tens", 3'b011, 7'h79);

    // 4: rem >= DENOM never latches
    drive(12, 7);
    hold(20, cnt);
    chk("t4_no_upd", cnt, 0);
    chk("t4_valid", valid, 1);
    wait_an_seg("t4_hold_rem", 3'b110, 7'h19);

    // 5: change every 3 clk, then hold
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      drive(i, i % 5);
      hold(3, cnt);
      tot += cnt;
    end
    chk("t5_no_upd", tot, 0);
    drive(3, 1);
    hold(10, cnt);
    chk("t5_one_upd", cnt, 1);

    // random segments; the per-cycle compare carries the checking
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 15), $urandom_range(0, 9));
      hold($urandom_range(1, 8), cnt);
    end

    // 6: asynchronous reset mid-scan
    drive(5, 2);
    hold(8, cnt);
    repeat (REFRESH + 3) @(negedge clk);
    chk("t6_pre_valid", valid, 1);
    #2 realreset = 1'b1;
    #1;
    chk("t6_an", an, 3'b111);
    chk("t6_seg", seg, 7'h7F);
    chk("t6_valid", valid, 0);
    @(negedge clk);
    realreset = 1'b0;
    drive(7, 4);
    hold(12, cnt);
    chk("t6_restart_upd", cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
